// File: rtl/rv_divide_pkg.sv
// Shared RV32M divide function codes, FSM state encoding and funct3 decode helpers.
// Pure definitions: no latency, no flow control.
package rv_divide_pkg;

    localparam logic [2:0] FUNC_DIV  = 3'b100;
    localparam logic [2:0] FUNC_DIVU = 3'b101;
    localparam logic [2:0] FUNC_REM  = 3'b110;
    localparam logic [2:0] FUNC_REMU = 3'b111;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    function automatic logic fun_is_signed(input logic [2:0] fun);
        return (fun == FUNC_DIV) || (fun == FUNC_REM);
    endfunction

    function automatic logic fun_is_rem(input logic [2:0] fun);
        return (fun == FUNC_REM) || (fun == FUNC_REMU);
    endfunction

endpackage

// File: rtl/rv_divide_if.sv
// Decode/execute-side bundle of the divider: operands in, result and stall request out.
// Wires only; master drives operands and stall, slave is the divider.
interface rv_divide_if #(
    parameter int g_width = 32
);
    logic               x_stall_i;
    logic               d_valid_i;
    logic               d_is_divide_i;
    logic [g_width-1:0] d_rs1_i;
    logic [g_width-1:0] d_rs2_i;
    logic [2:0]         d_fun_i;
    logic [g_width-1:0] x_rd_o;
    logic               x_stall_req_o;

    modport master (
        output x_stall_i, d_valid_i, d_is_divide_i, d_rs1_i, d_rs2_i, d_fun_i,
        input  x_rd_o, x_stall_req_o
    );

    modport slave (
        input  x_stall_i, d_valid_i, d_is_divide_i, d_rs1_i, d_rs2_i, d_fun_i,
        output x_rd_o, x_stall_req_o
    );
endinterface

// File: rtl/rv_divide.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; fixed 34-cycle latency from start to result.
// Holds the pipeline with a stall request while busy; result is held in DONE until the stage unstalls.
module rv_divide
    import rv_divide_pkg::*;
#(
    parameter int g_width = 32
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    rv_divide_if.slave bus
);

    div_state_t         state;
    div_state_t         state_nxt;
    logic               start;
    logic               stall_req;
    logic               op_signed;
    logic               rs1_neg;
    logic               rs2_neg;

    logic [2:0]         fun;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;
    logic [g_width-1:0] quo;
    logic [g_width-1:0] rem;
    logic [g_width-1:0] dvs;
    logic [g_width-1:0] rd;
    logic [CNT_W-1:0]   cnt;

    logic [g_width:0]   rem_sh;
    logic [g_width:0]   trial;
    logic [g_width-1:0] quo_fix;
    logic [g_width-1:0] rem_fix;

    assign op_signed = fun_is_signed(bus.d_fun_i);
    assign rs1_neg   = bus.d_rs1_i[g_width-1] & op_signed;
    assign rs2_neg   = bus.d_rs2_i[g_width-1] & op_signed;
    assign start     = (state == S_IDLE) & bus.d_valid_i & bus.d_is_divide_i & !bus.x_stall_i;

    // Partial remainder is always below the divisor, so after the shift a
    // borrow out of bit g_width means the trial subtraction went negative.
    assign rem_sh  = {rem, quo[g_width-1]};
    assign trial   = rem_sh - {1'b0, dvs};
    assign quo_fix = ((sign_a ^ sign_b) & !div_zero) ? -quo : quo;
    assign rem_fix = sign_a ? -rem : rem;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        case (state)
            S_IDLE: begin
                stall_req = bus.d_valid_i & bus.d_is_divide_i;
                if (start) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                stall_req = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!bus.x_stall_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fun      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            rd       <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fun      <= bus.d_fun_i;
                        sign_a   <= rs1_neg;
                        sign_b   <= rs2_neg;
                        div_zero <= (bus.d_rs2_i == '0);
                        quo      <= rs1_neg ? -bus.d_rs1_i : bus.d_rs1_i;
                        dvs      <= rs2_neg ? -bus.d_rs2_i : bus.d_rs2_i;
                        rem      <= '0;
                        cnt      <= CNT_W'(g_width - 1);
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (!trial[g_width]) begin
                        rem <= trial[g_width-1:0];
                        quo <= {quo[g_width-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[g_width-1:0];
                        quo <= {quo[g_width-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    rd <= fun_is_rem(fun) ? rem_fix : quo_fix;
                end
                default: ;
            endcase
        end
    end

    // Gated so the pipeline never sees a request while the block is held in reset.
    assign bus.x_stall_req_o = stall_req & rst_n_i;
    assign bus.x_rd_o        = rd;

endmodule

// File: tb/tb_rv_divide.sv
// Directed bench for rv_divide: table of operand/result vectors plus stall-hold and mid-op reset sequences.
module tb_rv_divide;
    import rv_divide_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    rv_divide_if #(.g_width(32)) bus();

    rv_divide #(.g_width(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int cyc;
        @(negedge clk);
        bus.d_fun_i       = f;
        bus.d_rs1_i       = a;
        bus.d_rs2_i       = b;
        bus.d_valid_i     = 1'b1;
        bus.d_is_divide_i = 1'b1;
        bus.x_stall_i     = 1'b0;
        #1 check({nm, "_req0"}, 32'(bus.x_stall_req_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        // Scramble operands after the start edge; the divider must have latched them.
        bus.d_valid_i = 1'b0;
        bus.d_rs1_i   = ~a;
        bus.d_rs2_i   = a ^ b ^ 32'h5A5A_0001;
        bus.d_fun_i   = ~f;
        while (bus.x_stall_req_o && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_lat"}, 32'(cyc), 32'd34);
        check({nm, "_res"}, bus.x_rd_o, exp);
    endtask

    initial begin
        vecs.push_back('{FUNC_DIVU, 32'd100,        32'd7,          32'd14,         "divu_100_7"});
        vecs.push_back('{FUNC_REMU, 32'd100,        32'd7,          32'd2,          "remu_100_7"});
        vecs.push_back('{FUNC_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   "div_m7_2"});
        vecs.push_back('{FUNC_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   "rem_m7_2"});
        vecs.push_back('{FUNC_DIVU, 32'h12345678,   32'd0,          32'hFFFFFFFF,   "divu_by0"});
        vecs.push_back('{FUNC_REMU, 32'h12345678,   32'd0,          32'h12345678,   "remu_by0"});
        vecs.push_back('{FUNC_DIV,  32'h12345678,   32'd0,          32'hFFFFFFFF,   "div_by0"});
        vecs.push_back('{FUNC_REM,  32'h12345678,   32'd0,          32'h12345678,   "rem_by0"});
        vecs.push_back('{FUNC_DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   "div_m5_by0"});
        vecs.push_back('{FUNC_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   "rem_m5_by0"});
        vecs.push_back('{FUNC_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "div_ovf"});
        vecs.push_back('{FUNC_REM,  32'h80000000,   32'hFFFFFFFF,   32'h00000000,   "rem_ovf"});
        vecs.push_back('{FUNC_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   "divu_big"});
        vecs.push_back('{FUNC_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "remu_big"});
        vecs.push_back('{FUNC_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   "div_7_m2"});
        vecs.push_back('{FUNC_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          "rem_7_m2"});
        vecs.push_back('{FUNC_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         "div_m100_m7"});
        vecs.push_back('{FUNC_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   "rem_m100_m7"});
        vecs.push_back('{FUNC_DIVU, 32'hFFFFFFFF,   32'h00010000,   32'h0000FFFF,   "divu_ffff"});
        vecs.push_back('{FUNC_REMU, 32'hFFFFFFFF,   32'h00010000,   32'h0000FFFF,   "remu_ffff"});
        vecs.push_back('{FUNC_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   "divu_by1"});

        // Reset with a divide presented: no stall request, cleared result.
        rst_n             = 1'b0;
        bus.x_stall_i     = 1'b0;
        bus.d_valid_i     = 1'b1;
        bus.d_is_divide_i = 1'b1;
        bus.d_fun_i       = FUNC_DIVU;
        bus.d_rs1_i       = 32'd100;
        bus.d_rs2_i       = 32'd7;
        #2;
        check("rst_req", 32'(bus.x_stall_req_o), 32'd0);
        check("rst_rd", bus.x_rd_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.d_valid_i = 1'b0;

        // Valid non-divide instruction must not request a stall or start.
        @(negedge clk);
        bus.d_valid_i     = 1'b1;
        bus.d_is_divide_i = 1'b0;
        #1 check("nondiv_req", 32'(bus.x_stall_req_o), 32'd0);
        @(negedge clk);
        check("nondiv_idle", 32'(bus.x_stall_req_o), 32'd0);
        bus.d_valid_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);
        end

        // External stall holds the result in DONE past cycle 34.
        @(negedge clk);
        bus.d_fun_i       = FUNC_DIVU;
        bus.d_rs1_i       = 32'd1000;
        bus.d_rs2_i       = 32'd10;
        bus.d_valid_i     = 1'b1;
        bus.d_is_divide_i = 1'b1;
        bus.x_stall_i     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.x_stall_i = 1'b1;
        bus.d_rs1_i   = 32'd9;
        bus.d_rs2_i   = 32'd3;
        repeat (33) @(negedge clk);
        check("stall_c34_req", 32'(bus.x_stall_req_o), 32'd0);
        check("stall_c34_rd", bus.x_rd_o, 32'd100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d_req", k), 32'(bus.x_stall_req_o), 32'd0);
            check($sformatf("stall_hold%0d_rd", k), bus.x_rd_o, 32'd100);
        end
        bus.x_stall_i = 1'b0;
        bus.d_valid_i = 1'b0;
        @(negedge clk);
        check("stall_rel_req", 32'(bus.x_stall_req_o), 32'd0);
        bus.d_valid_i = 1'b1;
        bus.x_stall_i = 1'b1;
        #1 check("stall_rel_idle", 32'(bus.x_stall_req_o), 32'd1);
        @(negedge clk);
        check("stall_rel_rd", bus.x_rd_o, 32'd100);
        bus.d_valid_i = 1'b0;
        bus.x_stall_i = 1'b0;

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        bus.d_fun_i       = FUNC_DIVU;
        bus.d_rs1_i       = 32'd1000;
        bus.d_rs2_i       = 32'd3;
        bus.d_valid_i     = 1'b1;
        bus.d_is_divide_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.d_valid_i = 1'b0;
        repeat (14) @(negedge clk);
        check("mid_busy_req", 32'(bus.x_stall_req_o), 32'd1);
        rst_n         = 1'b0;
        bus.d_valid_i = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus.x_stall_req_o), 32'd0);
        check("mid_rst_rd", bus.x_rd_o, 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.d_valid_i = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(bus.x_stall_req_o), 32'd0);
        run_op(FUNC_DIVU, 32'd9, 32'd3, 32'd3, "post_rst_divu_9_3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
